mem_access_ctrl: RTL and testbench

Memory-side handshake controller that sits directly downstream of the microprogrammed control unit. It consumes the control word's MFA, R/W and MAS fields plus the MAR address and MDR write data, performs a byte/halfword/word access on an internal byte-addressed RAM after a fixed number of wait states, and returns MFC. The control unit's condition mux loops on MFC. Access uses a four-phase handshake; read data feeds the MDR input path.

---
 rtl/mem_access_ctrl_pkg.sv | 40 ++++
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_access_ctrl_byte_array.sv | 31 +++
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: MAS size encodings,
// controller states, R/W polarity and the size/alignment helper functions.
package mem_pkg;

  typedef enum logic [1:0] {
    MAS_BYTE = 2'b00,
    MAS_HALF = 2'b01,
    MAS_WORD = 2'b10,
    MAS_RSVD = 2'b11
  } mas_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Access fault: misaligned halfword/word or the reserved size code.
  function automatic logic mas_fault(input logic [1:0] mas, input logic [1:0] a_lo);
    case (mas_e'(mas))
      MAS_BYTE: return 1'b0;
      MAS_HALF: return a_lo[0];
      MAS_WORD: return (a_lo != 2'b00);
      default:  return 1'b1;
    endcase
  endfunction

  // Byte-lane enables; the reserved code behaves as a word.
  function automatic logic [3:0] mas_be(input logic [1:0] mas);
    case (mas_e'(mas))
      MAS_BYTE: return 4'b0001;
      MAS_HALF: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit <-> memory handshake bundle (MFA/MFC four-phase handshake).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              mfa;
  logic              rw;
  logic [1:0]        mas;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              err;

  modport master (
    output mfa, rw, mas, addr, data_in,
    input  data_out, mfc, err
  );

  modport slave (
    input  mfa, rw, mas, addr, data_in,
    output data_out, mfc, err
  );
endinterface

// File: rtl/mem_access_ctrl_byte_array.sv
// Byte-addressed RAM, 2**ADDR_W x 8, with four byte lanes at addr..addr+3.
// Writes are synchronous per lane; the 4-byte read is combinational.
// Lane addresses wrap modulo the RAM depth. Contents are never reset.
module mem_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // per-lane byte write, lane i lands at addr+i
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
    end
  end

  // little-endian gather of the four bytes starting at addr
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[addr + ADDR_W'(i)];
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side MFA/MFC handshake controller with wait states.
// A request is captured in IDLE, spends WAIT_CYCLES+1 cycles in WAIT
// (one capture cycle followed by the wait states), commits on the
// WAIT->DONE edge and then holds MFC until MFA drops.
// Build option: define ALIGN_CHECK_EN to flag misaligned/reserved accesses
// on err; without it, addresses are force-aligned and err is tied low.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           CLR,
  mem_access_ctrl_if.slave bus
);

  state_e            state, state_nxt;
  logic [3:0]        cnt;
  logic              fault_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        mas_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_fault;
  logic              accept;
  logic              commit;
  logic [3:0]        we;
  logic [31:0]       rdata;
  logic [31:0]       rd_ext;
  logic [31:0]       data_out_q;

  // capture-time address alignment and fault evaluation
  always_comb begin
    cap_addr  = bus.addr;
    cap_fault = 1'b0;
`ifdef ALIGN_CHECK_EN
    cap_fault = mas_fault(bus.mas, bus.addr[1:0]);
`else
    case (mas_e'(bus.mas))
      MAS_HALF:           cap_addr[0]   = 1'b0;
      MAS_WORD, MAS_RSVD: cap_addr[1:0] = 2'b00;
      default:            ;
    endcase
`endif
  end

  // state register
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next state, request acceptance and commit strobe
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.mfa) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.mfa) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // wait-state counter and latched fault
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      cnt     <= 4'd0;
      fault_q <= 1'b0;
    end else if (accept) begin
      cnt     <= 4'(WAIT_CYCLES);
      fault_q <= cap_fault;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // request capture; later input changes are ignored until the next accept
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cap_addr;
      rw_q    <= bus.rw;
      mas_q   <= bus.mas;
      wdata_q <= bus.data_in;
    end
  end

  // byte-lane write enables and zero-extended read lane select
  always_comb begin
    we = (commit && !fault_q && rw_q == RW_WRITE) ? mas_be(mas_q) : 4'b0000;
    case (mas_e'(mas_q))
      MAS_BYTE: rd_ext = {24'h0, rdata[7:0]};
      MAS_HALF: rd_ext = {16'h0, rdata[15:0]};
      default:  rd_ext = rdata;
    endcase
  end

  mem_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // read data register, only a successful read updates it
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR)                                         data_out_q <= 32'h0;
    else if (commit && !fault_q && rw_q == RW_READ)   data_out_q <= rd_ext;
  end

  assign bus.data_out = data_out_q;
  assign bus.mfc      = (state == ST_DONE);
`ifdef ALIGN_CHECK_EN
  assign bus.err      = (state == ST_DONE) && fault_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a WAIT_CYCLES=2 instance driven from a vector
// table with a scoreboard queue, plus hand sequences for reset and handshake
// corner cases, and a WAIT_CYCLES=0 instance for the MFA hold case.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic CLR = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(8)) bus2 ();
  mem_access_ctrl_if #(.ADDR_W(8)) bus0 ();

  mem_access_ctrl #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk), .CLR (CLR), .bus (bus2)
  );
  mem_access_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .CLR (CLR), .bus (bus0)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  mas;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  vec_t tbl[15];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // count posedges (first one is the sampling edge) until mfc is seen
  task automatic wait_mfc(input bit use0, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      seen = use0 ? bus0.mfc : bus2.mfc;
    end
  endtask

  // full access on the WAIT_CYCLES=2 instance; call near a negedge
  task automatic do_access(input logic rw, input logic [1:0] mas, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                           input string tag);
    int   n;
    logic seen;
    exp_t e;
    sbq.push_back('{d: ed, e: ee});
    bus2.mfa = 1'b1; bus2.rw = rw; bus2.mas = mas; bus2.addr = a; bus2.data_in = wd;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus2.addr = ~a; bus2.data_in = ~wd; bus2.rw = ~rw; bus2.mas = ~mas;
      end
      seen = bus2.mfc;
    end
    check({tag, " latency"}, n, 4);
    e = sbq.pop_front();
    check({tag, " data_out"}, bus2.data_out, e.d);
    check({tag, " err"}, {31'h0, bus2.err}, {31'h0, e.e});
    @(negedge clk);
    bus2.mfa = 1'b0;
    @(posedge clk); #1;
    check({tag, " mfc drop"}, {31'h0, bus2.mfc}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    exp_t e;
    logic [31:0] held;

    tbl[0]  = '{RW_WRITE, MAS_WORD, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{RW_READ,  MAS_WORD, 8'h10, 32'h0,       32'hDEADBEEF, 1'b0};
    tbl[2]  = '{RW_READ,  MAS_BYTE, 8'h13, 32'h0,       32'h000000DE, 1'b0};
    tbl[3]  = '{RW_WRITE, MAS_BYTE, 8'h11, 32'h0000005A, 32'h000000DE, 1'b0};
    tbl[4]  = '{RW_READ,  MAS_WORD, 8'h10, 32'h0,       32'hDEAD5AEF, 1'b0};
    tbl[5]  = '{RW_READ,  MAS_HALF, 8'h12, 32'h0,       32'h0000DEAD, 1'b0};
    tbl[6]  = '{RW_WRITE, MAS_WORD, 8'h20, 32'hA5A5A5A5, 32'h0000DEAD, 1'b0};
`ifdef ALIGN_CHECK_EN
    tbl[7]  = '{RW_WRITE, MAS_WORD, 8'h21, 32'h12345678, 32'h0000DEAD, 1'b1};
    tbl[8]  = '{RW_READ,  MAS_WORD, 8'h20, 32'h0,       32'hA5A5A5A5, 1'b0};
    tbl[9]  = '{RW_READ,  MAS_HALF, 8'h13, 32'h0,       32'hA5A5A5A5, 1'b1};
    tbl[10] = '{RW_READ,  MAS_RSVD, 8'h10, 32'h0,       32'hA5A5A5A5, 1'b1};
    tbl[11] = '{RW_WRITE, MAS_HALF, 8'h32, 32'hFFFF1234, 32'hA5A5A5A5, 1'b0};
`else
    tbl[7]  = '{RW_WRITE, MAS_WORD, 8'h21, 32'h12345678, 32'h0000DEAD, 1'b0};
    tbl[8]  = '{RW_READ,  MAS_WORD, 8'h20, 32'h0,       32'h12345678, 1'b0};
    tbl[9]  = '{RW_READ,  MAS_HALF, 8'h13, 32'h0,       32'h0000DEAD, 1'b0};
    tbl[10] = '{RW_READ,  MAS_RSVD, 8'h10, 32'h0,       32'hDEAD5AEF, 1'b0};
    tbl[11] = '{RW_WRITE, MAS_HALF, 8'h32, 32'hFFFF1234, 32'hDEAD5AEF, 1'b0};
`endif
    tbl[12] = '{RW_READ,  MAS_HALF, 8'h32, 32'h0,       32'h00001234, 1'b0};
    tbl[13] = '{RW_READ,  MAS_BYTE, 8'h33, 32'h0,       32'h00000012, 1'b0};
    tbl[14] = '{RW_WRITE, MAS_WORD, 8'h40, 32'h11223344, 32'h00000012, 1'b0};

    bus2.mfa = 1'b0; bus2.rw = RW_READ; bus2.mas = MAS_BYTE; bus2.addr = '0; bus2.data_in = '0;
    bus0.mfa = 1'b0; bus0.rw = RW_READ; bus0.mas = MAS_BYTE; bus0.addr = '0; bus0.data_in = '0;

    // reset state
    #3;
    check("reset mfc", {31'h0, bus2.mfc}, 32'h0);
    check("reset err", {31'h0, bus2.err}, 32'h0);
    check("reset data_out", bus2.data_out, 32'h0);
    @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);

    // table-driven accesses
    for (int i = 0; i < 15; i++) begin
      do_access(tbl[i].rw, tbl[i].mas, tbl[i].a, tbl[i].wd, tbl[i].ed, tbl[i].ee,
                $sformatf("vec%0d", i));
    end

    // CLR pulse during WAIT discards the pending write
    bus2.mfa = 1'b1; bus2.rw = RW_WRITE; bus2.mas = MAS_WORD;
    bus2.addr = 8'h40; bus2.data_in = 32'hCAFEF00D;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    CLR = 1'b0;
    @(negedge clk);
    CLR = 1'b1;
    bus2.mfa = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort no mfc %0d", k), {31'h0, bus2.mfc}, 32'h0);
    end
    @(negedge clk);
    do_access(RW_READ, MAS_WORD, 8'h40, 32'h0, 32'h11223344, 1'b0, "abort readback");

    // mfa dropped during WAIT: access still completes, DONE exits next edge
    sbq.push_back('{d: 32'h0000DEAD, e: 1'b0});
    bus2.mfa = 1'b1; bus2.rw = RW_READ; bus2.mas = MAS_HALF; bus2.addr = 8'h12;
    @(posedge clk);
    @(negedge clk);
    bus2.mfa = 1'b0;
    n = 1;
    while (!bus2.mfc && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("early drop latency", n, 4);
    e = sbq.pop_front();
    check("early drop data_out", bus2.data_out, e.d);
    @(posedge clk); #1;
    check("early drop mfc exit", {31'h0, bus2.mfc}, 32'h0);
    @(negedge clk);

    // WAIT_CYCLES=0 instance: write, then read held for 5 cycles
    bus0.mfa = 1'b1; bus0.rw = RW_WRITE; bus0.mas = MAS_WORD;
    bus0.addr = 8'h10; bus0.data_in = 32'h0BADF00D;
    wait_mfc(1'b1, n);
    check("wc0 write latency", n, 2);
    check("wc0 write err", {31'h0, bus0.err}, 32'h0);
    @(negedge clk);
    bus0.mfa = 1'b0;
    @(negedge clk);
    sbq.push_back('{d: 32'h0BADF00D, e: 1'b0});
    bus0.mfa = 1'b1; bus0.rw = RW_READ;
    wait_mfc(1'b1, n);
    check("wc0 read latency", n, 2);
    e = sbq.pop_front();
    check("wc0 read data_out", bus0.data_out, e.d);
    held = bus0.data_out;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("wc0 hold mfc %0d", k), {31'h0, bus0.mfc}, 32'h1);
      check($sformatf("wc0 hold data %0d", k), bus0.data_out, 32'h0BADF00D);
    end
    @(negedge clk);
    bus0.mfa = 1'b0;
    @(posedge clk); #1;
    check("wc0 drop mfc", {31'h0, bus0.mfc}, 32'h0);
    @(negedge clk);
    sbq.push_back('{d: 32'h000000AD, e: 1'b0});
    bus0.mfa = 1'b1; bus0.mas = MAS_BYTE; bus0.addr = 8'h12;
    wait_mfc(1'b1, n);
    check("wc0 next latency", n, 2);
    e = sbq.pop_front();
    check("wc0 next data_out", bus0.data_out, e.d);
    check("wc0 prior hold", held, 32'h0BADF00D);
    @(negedge clk);
    bus0.mfa = 1'b0;
    @(negedge clk);

    // CLR in DONE clears outputs asynchronously; mfa at first edge after release accepted
    sbq.push_back('{d: 32'hDEAD5AEF, e: 1'b0});
    bus2.mfa = 1'b1; bus2.rw = RW_READ; bus2.mas = MAS_WORD; bus2.addr = 8'h10;
    wait_mfc(1'b0, n);
    check("done-reset latency", n, 4);
    e = sbq.pop_front();
    check("done-reset pre data_out", bus2.data_out, e.d);
    @(negedge clk);
    #2;
    CLR = 1'b0;
    #1;
    check("async clr mfc", {31'h0, bus2.mfc}, 32'h0);
    check("async clr err", {31'h0, bus2.err}, 32'h0);
    check("async clr data_out", bus2.data_out, 32'h0);
    @(negedge clk);
    CLR = 1'b1;
    do_access(RW_READ, MAS_WORD, 8'h10, 32'h0, 32'hDEAD5AEF, 1'b0, "post-reset read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
